reg_ram_1rw: RTL and testbench



---
 rtl/reg_ram_1rw.sv | 57 +++++
 tb/tb_reg_ram_1rw.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_ram_1rw.sv
// ============================================================================
//  Module      : reg_ram_1rw
//  Description : Single-port register-array RAM, shared address, one write
//                port and a 1-cycle registered read port. Read-during-write is
//                read-first unless REG_RAM_WRITE_FIRST_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_ram_1rw #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LG_DEPTH-1:0] addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_en,
  output logic [WIDTH-1:0]    rd_data
);

  localparam int c_DEPTH = 2 ** LG_DEPTH;

  logic [WIDTH-1:0] r_mem [c_DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             w_wr_fire;

  assign w_wr_fire = wr_en && !reset;

  // Storage has no reset; only the write is gated so reset drops a pending write.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
`ifdef REG_RAM_WRITE_FIRST_EN
      if (wr_en) begin
        r_rd_data <= wr_data;
      end else begin
        r_rd_data <= r_mem[addr];
      end
`else
      r_rd_data <= r_mem[addr];
`endif
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_ram_1rw.sv
// ============================================================================
//  Module      : tb_reg_ram_1rw
//  Description : Directed self-checking bench for reg_ram_1rw (8x16 and 1x512).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_ram_1rw;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] rd_data;

  logic       n_reset;
  logic [8:0] n_addr;
  logic       n_wr_data;
  logic       n_wr_en;
  logic       n_rd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_ram_1rw #(.WIDTH(8), .LG_DEPTH(4)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_data (rd_data)
  );

  reg_ram_1rw #(.WIDTH(1), .LG_DEPTH(9)) u_narrow (
    .clk     (clk),
    .reset   (n_reset),
    .addr    (n_addr),
    .wr_data (n_wr_data),
    .wr_en   (n_wr_en),
    .rd_data (n_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] exp_rdw;
    logic [7:0] exp_lat;
    reset = 1'b0; addr = '0; wr_data = '0; wr_en = 1'b0;
    n_reset = 1'b1; n_addr = '0; n_wr_data = 1'b0; n_wr_en = 1'b1;

    // Reset suppresses writes and clears rd_data; mem keeps contents.
    wr(4'd3, 8'h55);
    reset = 1'b1; addr = 4'd3; wr_data = 8'hAA; wr_en = 1'b1;
    tick();
    check("reset_rd_c1", rd_data, 8'h00);
    check("narrow_reset_rd", n_rd_data, 1'b0);
    tick();
    check("reset_rd_c2", rd_data, 8'h00);
    reset = 1'b0; wr_en = 1'b0; addr = 4'd3;
    tick();
    check("reset_kept_mem3", rd_data, 8'h55);

    // No combinational path: changing addr mid-cycle leaves rd_data alone.
    addr = 4'd9;
    #2;
    check("no_comb_path", rd_data, 8'h55);

    // Write/read latency on addr 7 (pre-cleared to 0x00).
    wr(4'd7, 8'h00);
    wr(4'd7, 8'h5A);
`ifdef REG_RAM_WRITE_FIRST_EN
    exp_lat = 8'h5A;
`else
    exp_lat = 8'h00;
`endif
    check("lat_write_edge", rd_data, exp_lat);
    wr_en = 1'b0; addr = 4'd7;
    tick();
    check("lat_read_7", rd_data, 8'h5A);

    // Read-during-write on addr 2.
    wr(4'd2, 8'h11);
    wr(4'd2, 8'h22);
`ifdef REG_RAM_WRITE_FIRST_EN
    exp_rdw = 8'h22;
`else
    exp_rdw = 8'h11;
`endif
    check("rdw_same_cycle", rd_data, exp_rdw);
    wr_en = 1'b0; addr = 4'd2;
    tick();
    check("rdw_followup", rd_data, 8'h22);

    // Full sweep: write idx^0xC3, then read back-to-back.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 8'(i) ^ 8'hC3);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      check($sformatf("sweep_rd_%0d", i), rd_data, 8'(i) ^ 8'hC3);
    end

    // Reset during the addr 5 write: write dropped, addr 4 kept.
    wr(4'd4, 8'h77);
    reset = 1'b1; addr = 4'd5; wr_data = 8'h88; wr_en = 1'b1;
    tick();
    check("midreset_rd", rd_data, 8'h00);
    reset = 1'b0; wr_en = 1'b0; addr = 4'd4;
    tick();
    check("midreset_mem4", rd_data, 8'h77);
    addr = 4'd5;
    tick();
    check("midreset_mem5", rd_data, 8'h05 ^ 8'hC3);

    // Narrow instance: ones only at 0 and 511.
    n_reset = 1'b0;
    for (int i = 0; i < 512; i++) begin
      n_addr = 9'(i); n_wr_data = (i == 0 || i == 511); n_wr_en = 1'b1;
      tick();
    end
    n_wr_en = 1'b0;
    for (int i = 0; i < 512; i++) begin
      n_addr = 9'(i);
      tick();
      check($sformatf("narrow_rd_%0d", i), {31'd0, n_rd_data}, (i == 0 || i == 511) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
